// File: rtl/regbank_seq_pkg.sv
// Shared types for the registerbank instruction sequencer: FSM states,
// opcode values and the 16-bit instruction word layout.
package regbank_seq_pkg;

    localparam int INSTR_W = 16;
    localparam int OP_W    = 4;
    localparam int ADDR_W  = 4;
    localparam int TGT_W   = 2;
    localparam int ALU_W   = 3;
    localparam int RSVD_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_READ,
        ST_EXEC,
        ST_WB,
        ST_HALTED
    } state_t;

    // Opcodes 1-7 are ALU functions; A-E are undefined.
    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'h0,
        OP_JMP  = 4'h8,
        OP_JZ   = 4'h9,
        OP_HALT = 4'hF
    } opcode_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [TGT_W-1:0]  target;
        logic [ADDR_W-1:0] src1;
        logic [ADDR_W-1:0] src2;
        logic [RSVD_W-1:0] rsvd;
    } instr_t;

endpackage

// File: rtl/regbank_sequencer_if.sv
// Instruction-fetch handshake between the sequencer (master) and
// instruction memory (slave).
interface regbank_sequencer_if;
    logic        fetchRequest;
    logic [15:0] fetchAddress;
    logic        fetchValid;
    logic [15:0] fetchData;

    modport master (output fetchRequest, output fetchAddress,
                    input  fetchValid,   input  fetchData);
    modport slave  (input  fetchRequest, input  fetchAddress,
                    output fetchValid,   output fetchData);
endinterface

// File: rtl/seq_decode.sv
// Combinational opcode classifier for the latched instruction register.
module seq_decode
    import regbank_seq_pkg::*;
(
    input  logic [OP_W-1:0]  op_i,
    output logic             isAlu_o,
    output logic             isJmp_o,
    output logic             isJz_o,
    output logic             isHalt_o,
    output logic             illegal_o,
    output logic [ALU_W-1:0] aluOp_o
);

    always_comb begin
        isAlu_o   = 1'b0;
        isJmp_o   = 1'b0;
        isJz_o    = 1'b0;
        isHalt_o  = 1'b0;
        illegal_o = 1'b0;
        aluOp_o   = '0;
        case (op_i)
            OP_NOP:  ;
            OP_JMP:  isJmp_o  = 1'b1;
            OP_JZ:   isJz_o   = 1'b1;
            OP_HALT: isHalt_o = 1'b1;
            default: begin
                // Low half of the opcode space is the ALU, the rest of the upper half is undefined.
                if (!op_i[3]) begin
                    isAlu_o = 1'b1;
                    aluOp_o = op_i[ALU_W-1:0];
                end else begin
                    illegal_o = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/regbank_sequencer.sv
// Four-phase (FETCH/READ/EXEC/WB) instruction sequencer driving the
// registerbank read/write/jump controls and the ALU opcode.
module regbank_sequencer
    import regbank_seq_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [INSTR_W-1:0]    instructionPointer_i,
    input  logic                  zeroFlag_i,
    regbank_sequencer_if.master   fetch,
    output logic [ADDR_W-1:0]     source1Address_o,
    output logic [ADDR_W-1:0]     source2Address_o,
    output logic [TGT_W-1:0]      targetAddress_o,
    output logic                  targetWriteEnable_o,
    output logic                  jump_o,
    output logic [ALU_W-1:0]      aluOp_o,
    output logic                  halted_o,
    output logic                  illegalOp_o,
    output logic                  fetchError_o
);

    localparam int CNT_W = (FETCH_TIMEOUT > 0) ? $clog2(FETCH_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FETCH_TIMEOUT);

    state_t               state_q;
    instr_t               instrReg_q;
    logic [INSTR_W-1:0]   fetchAddress_q;
    logic [CNT_W-1:0]     timeoutCnt_q;
    logic                 targetWriteEnable_q;
    logic                 jump_q;
    logic [ALU_W-1:0]     aluOp_q;
    logic                 illegalOp_q;
    logic                 fetchError_q;

    logic                 decAlu;
    logic                 decJmp;
    logic                 decJz;
    logic                 decHalt;
    logic                 decIllegal;
    logic [ALU_W-1:0]     decAluOp;
    logic                 timeoutExpired;
    logic                 unusedRsvd;

    seq_decode uDecode (
        .op_i      (instrReg_q.op),
        .isAlu_o   (decAlu),
        .isJmp_o   (decJmp),
        .isJz_o    (decJz),
        .isHalt_o  (decHalt),
        .illegal_o (decIllegal),
        .aluOp_o   (decAluOp)
    );

    // The fetch arriving in the expiry cycle still wins, because fetchValid is tested first.
    assign timeoutExpired = (FETCH_TIMEOUT != 0) && (timeoutCnt_q == CNT_LAST);
    assign unusedRsvd     = ^instrReg_q.rsvd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= ST_IDLE;
            instrReg_q          <= '0;
            fetchAddress_q      <= '0;
            timeoutCnt_q        <= '0;
            targetWriteEnable_q <= 1'b0;
            jump_q              <= 1'b0;
            aluOp_q             <= '0;
            illegalOp_q         <= 1'b0;
            fetchError_q        <= 1'b0;
        end else begin
            targetWriteEnable_q <= 1'b0;
            jump_q              <= 1'b0;
            aluOp_q             <= '0;
            illegalOp_q         <= 1'b0;
            fetchError_q        <= 1'b0;
            case (state_q)
                ST_IDLE, ST_HALTED: begin
                    if (start_i) begin
                        state_q        <= ST_FETCH;
                        fetchAddress_q <= instructionPointer_i;
                        timeoutCnt_q   <= '0;
                    end
                end
                ST_FETCH: begin
                    if (fetch.fetchValid) begin
                        instrReg_q <= instr_t'(fetch.fetchData);
                        state_q    <= ST_READ;
                    end else if (timeoutExpired) begin
                        fetchError_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else if (timeoutCnt_q != CNT_SAT) begin
                        timeoutCnt_q <= timeoutCnt_q + 1'b1;
                    end
                end
                ST_READ: begin
                    aluOp_q     <= decAluOp;
                    illegalOp_q <= decIllegal;
                    state_q     <= ST_EXEC;
                end
                ST_EXEC: begin
                    // Write and jump come from disjoint opcode classes, so they never coincide.
                    targetWriteEnable_q <= decAlu;
                    jump_q              <= decJmp | (decJz & zeroFlag_i);
                    state_q             <= ST_WB;
                end
                ST_WB: begin
                    if (decHalt) begin
                        state_q <= ST_HALTED;
                    end else begin
                        state_q        <= ST_FETCH;
                        fetchAddress_q <= instructionPointer_i;
                        timeoutCnt_q   <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fetch.fetchRequest = (state_q == ST_FETCH);
    assign fetch.fetchAddress = fetchAddress_q;
    assign halted_o           = (state_q == ST_HALTED);

    assign source1Address_o    = instrReg_q.src1;
    assign source2Address_o    = instrReg_q.src2;
    assign targetAddress_o     = instrReg_q.target;
    assign targetWriteEnable_o = targetWriteEnable_q;
    assign jump_o              = jump_q;
    assign aluOp_o             = aluOp_q;
    assign illegalOp_o         = illegalOp_q;
    assign fetchError_o        = fetchError_q;

endmodule
